lighthouse_pulse_decoder: RTL
=============================

LIGHTHOUSE_PULSE_DECODER -- requirements
Module: lighthouse_pulse_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 48_000_000, system clock frequency; tick constants are derived from it, and the values below hold at 48 MHz.
REQ-002 SHALL have parameter SWEEP_TIMEOUT, default 400_000, maximum ticks from sync to sweep (8.33 ms).
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port allow_capture, input, 1, sensor configured; it is driven by cfg_done.
REQ-006 SHALL have port envelope_input, input, 1, asynchronous TS4231 E line; high means light.
REQ-007 SHALL have ports sweep_valid (output, 1, one-cycle strobe), sweep_ticks (output, 20, sync-to-sweep-centre ticks), sweep_axis (output, 1) and sweep_lh (output, 1, lighthouse index).
REQ-008 SHALL have ports ootx_valid (output, 1, strobe), ootx_bit (output, 1) and ootx_lh (output, 1).
REQ-009 SHALL have port pulse_error (output, 1, one-cycle strobe on an unclassifiable pulse or a timeout).

Function
REQ-010 SHALL pass envelope_input through a 2-FF synchronizer; all edges are taken on the synchronized signal env_s.
REQ-011 SHALL have FSM states IDLE, ARM, LOW, HIGH.
- IDLE → ARM when allow_capture=1.
- ARM → LOW when env_s=0.
- LOW → HIGH on the rising edge.
- HIGH → LOW on the falling edge.
- Any state → IDLE when allow_capture=0, the same cycle.
REQ-012 SHALL ignore any pulse already high on entry to ARM.
REQ-013 SHALL hold a 14-bit width counter: cleared on the rising edge, +1 per HIGH cycle, saturating at 16383.
REQ-014 SHALL classify the pulse on the falling edge, width w:
- w<2000: sweep.
- 2750≤w≤6749: sync with code n=(w-2750)/500, where skip=n[2], data=n[1], axis=n[0].
- otherwise: pulse_error.
REQ-015 SHALL assign sync index: 1 if the rising edge is within 24_000 ticks of the previous sync's rising edge, else 0.
REQ-016 SHALL, on every valid sync, emit ootx_valid=1 with ootx_bit=data and ootx_lh=index, one cycle after the falling edge.
REQ-017 SHALL, on a sync with skip=0, latch axis and index and restart a 20-bit since-sync counter from the rising-edge timestamp.
REQ-018 SHALL, on a sweep with an armed non-skip sync, emit sweep_valid with sweep_ticks = rise_offset + (w>>1), one cycle after the falling edge, then disarm.
REQ-019 SHALL ignore a sweep arriving with no armed sync; no strobe is produced.
REQ-020 SHALL, when the since-sync counter reaches SWEEP_TIMEOUT, disarm and pulse pulse_error once; the counter saturates.
REQ-021 SHALL let a new non-skip sync while armed replace the previous one silently.
REQ-022 SHALL hold all strobes for exactly one cycle; data outputs hold their values until the next strobe.

Reset
REQ-023 SHALL, on reset, put the FSM in IDLE, clear all counters, disarm, and set all outputs to 0, the synchronizer included.
REQ-024 SHALL discard any pulse in progress when reset is asserted mid-pulse; nothing is emitted for it.

Structure
REQ-025 SHALL take tick constants (2000, 2750, 500, 6749, 24_000) and the state enumeration from a shared package lighthouse_pkg.
REQ-026 SHALL split the synchronizer, edge detection and width counter into one sub-module, pulse_width_meter.

Verification
REQ-027 SHALL cover: sync of 3000 ticks (n=0), then a 100-tick sweep rising at 100_000 ticks → sweep_valid=1, sweep_ticks=100_050, axis=0, lh=0.
REQ-028 SHALL cover: sync A of 3500 (axis=1), then sync B of 5000 (skip, n=4) 20_000 ticks later, then a sweep → ootx strobes with lh 0 then 1; sweep_axis=1, sweep_lh=0.
REQ-029 SHALL cover: a 7000-tick pulse → pulse_error for 1 cycle; no ootx or sweep output.
REQ-030 SHALL cover: a non-skip sync with no sweep for 400_000 ticks → one pulse_error; a later 100-tick pulse produces no sweep_valid.
REQ-031 SHALL cover: envelope high when allow_capture rises → that pulse is ignored, and the next 3000-tick sync is decoded.
REQ-032 SHALL cover: reset asserted mid-sync → all outputs 0, and no strobe follows the eventual falling edge.

Source files
------------

// File: rtl/lighthouse_pkg.sv
// Shared constants, state encoding and helpers for the Lighthouse pulse decoder.
// Tick thresholds are stated at 48 MHz and rescaled to the actual clock by scale_ticks().
package lighthouse_pkg;

    localparam int REF_CLK_HZ       = 48_000_000;
    localparam int WIDTH_W          = 14;
    localparam int TICK_W           = 20;

    localparam int SWEEP_MAX_W_48M  = 2000;
    localparam int SYNC_MIN_W_48M   = 2750;
    localparam int SYNC_STEP_48M    = 500;
    localparam int SYNC_MAX_W_48M   = 6749;
    localparam int SYNC_WINDOW_48M  = 24_000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ARM  = 2'd1;
    localparam state_t ST_LOW  = 2'd2;
    localparam state_t ST_HIGH = 2'd3;

    function automatic int scale_ticks(int base, int clk_hz);
        longint prod;
        prod = longint'(base) * longint'(clk_hz);
        return int'(prod / longint'(REF_CLK_HZ));
    endfunction

    // Sync code n = (w - min_w) / step, done as a compare ladder instead of a divider.
    function automatic logic [2:0] sync_code(logic [WIDTH_W-1:0] w, int min_w, int step);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(w) >= min_w + i * step) n = 3'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/pulse_width_meter.sv
// Synchronizes the TS4231 envelope line, flags its edges and counts high-time in ticks.
// ready rises once the synchronizer holds a real sample after reset.
module pulse_width_meter
    import lighthouse_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               envelope_input,
    output logic               env_s,
    output logic               ready,
    output logic               rise,
    output logic               fall,
    output logic [WIDTH_W-1:0] width
);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic [1:0]         ready_q, ready_d;
    logic [WIDTH_W-1:0] width_q, width_d;

    assign env_s = sync2_q;
    assign ready = ready_q[1];
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;
    assign width = width_q;

    // The rising-edge cycle is itself the first high tick, so the count restarts at 1.
    always_comb begin
        sync1_d = envelope_input;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ready_d = {ready_q[0], 1'b1};
        width_d = width_q;
        if (rise) begin
            width_d = {{(WIDTH_W-1){1'b0}}, 1'b1};
        end else if (sync2_q && (width_q != {WIDTH_W{1'b1}})) begin
            width_d = width_q + {{(WIDTH_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            ready_q <= 2'b00;
            width_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ready_q <= ready_d;
            width_q <= width_d;
        end
    end

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Classifies Lighthouse envelope pulses into sync (OOTX bit, axis, skip) and sweep events,
// reporting sweep timing relative to the latest non-skip sync.
module lighthouse_pulse_decoder
    import lighthouse_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 48_000_000,
    parameter int SWEEP_TIMEOUT = 400_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        allow_capture,
    input  logic        envelope_input,
    output logic        sweep_valid,
    output logic [19:0] sweep_ticks,
    output logic        sweep_axis,
    output logic        sweep_lh,
    output logic        ootx_valid,
    output logic        ootx_bit,
    output logic        ootx_lh,
    output logic        pulse_error,
    output logic [1:0]  state_dbg
);

    localparam int SWEEP_MAX = scale_ticks(SWEEP_MAX_W_48M, CLK_FREQ_HZ);
    localparam int SYNC_MIN  = scale_ticks(SYNC_MIN_W_48M, CLK_FREQ_HZ);
    localparam int SYNC_STEP = scale_ticks(SYNC_STEP_48M, CLK_FREQ_HZ);
    localparam int SYNC_MAX  = scale_ticks(SYNC_MAX_W_48M, CLK_FREQ_HZ);
    localparam logic [TICK_W-1:0] WINDOW_T  = TICK_W'(scale_ticks(SYNC_WINDOW_48M, CLK_FREQ_HZ));
    localparam logic [TICK_W-1:0] TIMEOUT_T = TICK_W'(SWEEP_TIMEOUT);
    localparam logic [TICK_W-1:0] ONE_T     = {{(TICK_W-1){1'b0}}, 1'b1};

    logic               env_s, ready, rise, fall;
    logic [WIDTH_W-1:0] width;

    pulse_width_meter u_meter (
        .clock          (clock),
        .reset          (reset),
        .envelope_input (envelope_input),
        .env_s          (env_s),
        .ready          (ready),
        .rise           (rise),
        .fall           (fall),
        .width          (width)
    );

    state_t            state_q, state_d;
    logic [TICK_W-1:0] since_q, since_d, age_q, age_d;
    logic [TICK_W-1:0] rise_off_q, rise_off_d, rise_age_q, rise_age_d;
    logic              prev_valid_q, prev_valid_d;
    logic              armed_q, armed_d, armed_axis_q, armed_axis_d, armed_lh_q, armed_lh_d;
    logic              sweep_valid_q, sweep_valid_d, sweep_axis_q, sweep_axis_d;
    logic              sweep_lh_q, sweep_lh_d;
    logic [TICK_W-1:0] sweep_ticks_q, sweep_ticks_d;
    logic              ootx_valid_q, ootx_valid_d, ootx_bit_q, ootx_bit_d, ootx_lh_q, ootx_lh_d;
    logic              pulse_error_q, pulse_error_d;

    logic              classify, is_sweep, is_sync, sync_index, timeout;
    logic [2:0]        code;
    logic [TICK_W-1:0] width_plus1;

    // ARM waits for a settled low line so a pulse already in flight is never measured.
    always_comb begin
        state_d = state_q;
        if (!allow_capture) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (ready && !env_s) state_d = ST_LOW;
                ST_LOW:  if (rise) state_d = ST_HIGH;
                ST_HIGH: if (fall) state_d = ST_LOW;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign classify    = fall && (state_q == ST_HIGH);
    assign is_sweep    = int'(width) < SWEEP_MAX;
    assign is_sync     = (int'(width) >= SYNC_MIN) && (int'(width) <= SYNC_MAX);
    assign code        = sync_code(width, SYNC_MIN, SYNC_STEP);
    assign sync_index  = prev_valid_q && (rise_age_q <= WINDOW_T);
    assign timeout     = armed_q && (since_q == TIMEOUT_T);
    // At the falling edge the pulse's rise lies width ticks back; the reload value is for the next cycle.
    assign width_plus1 = {{(TICK_W-WIDTH_W){1'b0}}, width} + ONE_T;

    always_comb begin
        since_d       = (since_q == TIMEOUT_T) ? since_q : since_q + ONE_T;
        age_d         = (&age_q) ? age_q : age_q + ONE_T;
        rise_off_d    = rise_off_q;
        rise_age_d    = rise_age_q;
        prev_valid_d  = prev_valid_q;
        armed_d       = armed_q;
        armed_axis_d  = armed_axis_q;
        armed_lh_d    = armed_lh_q;
        sweep_valid_d = 1'b0;
        sweep_ticks_d = sweep_ticks_q;
        sweep_axis_d  = sweep_axis_q;
        sweep_lh_d    = sweep_lh_q;
        ootx_valid_d  = 1'b0;
        ootx_bit_d    = ootx_bit_q;
        ootx_lh_d     = ootx_lh_q;
        pulse_error_d = 1'b0;

        if (rise && (state_q == ST_LOW)) begin
            rise_off_d = since_q;
            rise_age_d = age_q;
        end
        if (timeout) begin
            armed_d       = 1'b0;
            pulse_error_d = 1'b1;
        end
        if (classify) begin
            if (is_sweep) begin
                if (armed_q && !timeout) begin
                    sweep_valid_d = 1'b1;
                    sweep_ticks_d = rise_off_q + {{(TICK_W-WIDTH_W+1){1'b0}}, width[WIDTH_W-1:1]};
                    sweep_axis_d  = armed_axis_q;
                    sweep_lh_d    = armed_lh_q;
                    armed_d       = 1'b0;
                end
            end else if (is_sync) begin
                ootx_valid_d = 1'b1;
                ootx_bit_d   = code[1];
                ootx_lh_d    = sync_index;
                age_d        = width_plus1;
                prev_valid_d = 1'b1;
                if (!code[2]) begin
                    armed_d      = 1'b1;
                    armed_axis_d = code[0];
                    armed_lh_d   = sync_index;
                    since_d      = width_plus1;
                end
            end else begin
                pulse_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            since_q       <= '0;
            age_q         <= '0;
            rise_off_q    <= '0;
            rise_age_q    <= '0;
            prev_valid_q  <= 1'b0;
            armed_q       <= 1'b0;
            armed_axis_q  <= 1'b0;
            armed_lh_q    <= 1'b0;
            sweep_valid_q <= 1'b0;
            sweep_ticks_q <= '0;
            sweep_axis_q  <= 1'b0;
            sweep_lh_q    <= 1'b0;
            ootx_valid_q  <= 1'b0;
            ootx_bit_q    <= 1'b0;
            ootx_lh_q     <= 1'b0;
            pulse_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            since_q       <= since_d;
            age_q         <= age_d;
            rise_off_q    <= rise_off_d;
            rise_age_q    <= rise_age_d;
            prev_valid_q  <= prev_valid_d;
            armed_q       <= armed_d;
            armed_axis_q  <= armed_axis_d;
            armed_lh_q    <= armed_lh_d;
            sweep_valid_q <= sweep_valid_d;
            sweep_ticks_q <= sweep_ticks_d;
            sweep_axis_q  <= sweep_axis_d;
            sweep_lh_q    <= sweep_lh_d;
            ootx_valid_q  <= ootx_valid_d;
            ootx_bit_q    <= ootx_bit_d;
            ootx_lh_q     <= ootx_lh_d;
            pulse_error_q <= pulse_error_d;
        end
    end

    assign sweep_valid = sweep_valid_q;
    assign sweep_ticks = sweep_ticks_q;
    assign sweep_axis  = sweep_axis_q;
    assign sweep_lh    = sweep_lh_q;
    assign ootx_valid  = ootx_valid_q;
    assign ootx_bit    = ootx_bit_q;
    assign ootx_lh     = ootx_lh_q;
    assign pulse_error = pulse_error_q;
    assign state_dbg   = state_q;

endmodule
